// File: rtl/trig_cap_pkg.sv
// Shared types and width helpers for the trigger edge-capture block.
// Channel state encoding, counter saturation value and counter-width helper.
package trig_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCHED = 2'd1,
    ST_DEAD    = 2'd2
  } ch_state_t;

  // Bits needed to hold the value v (never less than one).
  function automatic int bits_for(int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  // All-ones value of a w-bit hit counter, the point where it stops counting.
  function automatic logic [63:0] cnt_sat(int w);
    return (64'(1) << w) - 64'(1);
  endfunction

endpackage

// File: rtl/trig_edge_capture_ch.sv
// One trigger channel: input synchroniser, rising-edge detect, hold/clear/dead FSM.
// With TRIG_HIT_COUNT_EN defined it also keeps a saturating hit counter.
module trig_edge_capture_ch
  import trig_cap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int DEAD_CYCLES = 8
`ifdef TRIG_HIT_COUNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_i,
  input  logic             en,
  input  logic             clr,
  input  logic             armed,
`ifdef TRIG_HIT_COUNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic             q_o,
  output logic             busy_o
);

  localparam int HW = bits_for(HOLD_CYCLES - 1);
  localparam int DW = bits_for((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DEAD_INIT = DW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  ch_state_t              state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [DW-1:0]          dead_q, dead_d;
  logic                   pend_q, pend_d;
  logic                   q_q, q_d;
  logic                   busy_q, busy_d;
  logic                   rise;

  // The chain runs regardless of en so re-enabling never creates a false edge.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
  assign prev_d = sync_q[SYNC_STAGES-1];
  assign rise   = armed & sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    pend_d  = pend_q;
    if (!en) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A clear arriving with the edge drops the edge.
          if (rise && !clr) begin
            state_d = ST_LATCHED;
            hold_d  = HOLD_INIT;
            pend_d  = 1'b0;
          end
        end
        ST_LATCHED: begin
          if (hold_q != '0) hold_d = hold_q - 1'b1;
          if (hold_q == '0 && (clr || pend_q)) begin
            pend_d = 1'b0;
            if (DEAD_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DEAD;
              dead_d  = DEAD_INIT;
            end
          end else begin
            pend_d = pend_q | clr;
          end
        end
        ST_DEAD: begin
          if (dead_q == '0) state_d = ST_IDLE;
          else              dead_d  = dead_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    q_d    = (state_d == ST_LATCHED);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= ST_IDLE;
      hold_q  <= '0;
      dead_q  <= '0;
      pend_q  <= 1'b0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      pend_q  <= pend_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
    end
  end

  assign q_o    = q_q;
  assign busy_o = busy_q;

`ifdef TRIG_HIT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take;

  assign take = (state_q == ST_IDLE) && (state_d == ST_LATCHED);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                        cnt_d = '0;
    else if (take && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/trig_edge_capture.sv
// Multi-channel trigger input capture: WIDTH channels plus a shared arming counter.
// Define TRIG_HIT_COUNT_EN to add per-channel hit counters and the cnt_out read port.
module trig_edge_capture
  import trig_cap_pkg::*;
#(
  parameter  int WIDTH       = 48,
  parameter  int SYNC_STAGES = 2,
  parameter  int HOLD_CYCLES = 4,
  parameter  int DEAD_CYCLES = 8,
  parameter  int CNT_W       = 16,
  localparam int SEL_W       = bits_for(WIDTH - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_i,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] clr,
`ifdef TRIG_HIT_COUNT_EN
  input  logic [SEL_W-1:0] cnt_sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_out,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] busy
);

  // Edges stay suppressed until the synchronisers have flushed their reset state.
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int AW         = bits_for(ARM_CYCLES);

  logic [AW-1:0] arm_q, arm_d;
  logic          armed;

  assign armed = (arm_q == AW'(ARM_CYCLES));
  assign arm_d = armed ? arm_q : arm_q + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) arm_q <= '0;
    else     arm_q <= arm_d;
  end

`ifdef TRIG_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt_arr [WIDTH];
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    trig_edge_capture_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .DEAD_CYCLES (DEAD_CYCLES)
`ifdef TRIG_HIT_COUNT_EN
      ,
      .CNT_W       (CNT_W)
`endif
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .in_i    (in_i[i]),
      .en      (en[i]),
      .clr     (clr[i]),
      .armed   (armed),
`ifdef TRIG_HIT_COUNT_EN
      .cnt_clr (cnt_clr),
      .cnt_o   (cnt_arr[i]),
`endif
      .q_o     (q[i]),
      .busy_o  (busy[i])
    );
  end

`ifdef TRIG_HIT_COUNT_EN
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;

  always_comb begin
    cnt_out_d = '0;
    if (int'(cnt_sel) < WIDTH) cnt_out_d = cnt_arr[cnt_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_out_q <= '0;
    else     cnt_out_q <= cnt_out_d;
  end

  assign cnt_out = cnt_out_q;
`endif

endmodule

// File: tb/tb_trig_edge_capture.sv
// Bench for trig_edge_capture: directed scenarios plus random traffic against a
// timestamp-based reference model (edge time, acceptance time, release time).
module tb_trig_edge_capture;

  localparam int W     = 48;
  localparam int SYNC  = 2;
  localparam int HOLD  = 4;
  localparam int DEAD  = 8;
  localparam int CW    = 4;
  localparam int SEL_W = $clog2(W);
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     in_i, en, clr, q, busy;
  logic [SEL_W-1:0] cnt_sel;
  logic             cnt_clr;
`ifdef TRIG_HIT_COUNT_EN
  logic [CW-1:0]    cnt_out;
`endif

  trig_edge_capture #(
    .WIDTH       (W),
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD),
    .DEAD_CYCLES (DEAD),
    .CNT_W       (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_i    (in_i),
    .en      (en),
    .clr     (clr),
`ifdef TRIG_HIT_COUNT_EN
    .cnt_sel (cnt_sel),
    .cnt_clr (cnt_clr),
    .cnt_out (cnt_out),
`endif
    .q       (q),
    .busy    (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per channel: posedge index of acceptance (-1 when not holding), whether a
  // clear was seen while holding, and the first posedge an edge may be accepted.
  int           k;
  int           acc_t   [W];
  bit           seen    [W];
  int           free_at [W];
  int           hits    [W];
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_busy_q[$];
  logic [CW-1:0] exp_cnt_q[$];

  task automatic model_reset();
    k = 0;
    hist.delete();
    repeat (SYNC + 2) hist.push_front('0);
    for (int i = 0; i < W; i++) begin
      acc_t[i] = -1; seen[i] = 1'b0; free_at[i] = 0; hits[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [W-1:0]  eq, eb, h_new, h_old;
    logic [CW-1:0] ec;
    bit            rise;
    ec = (int'(cnt_sel) < W) ? CW'(hits[cnt_sel]) : '0;
    k++;
    hist.push_front(in_i);
    void'(hist.pop_back());
    h_new = hist[SYNC];
    h_old = hist[SYNC + 1];
    for (int i = 0; i < W; i++) begin
      rise = (k >= SYNC + 2) && h_new[i] && !h_old[i];
      if (!en[i]) begin
        acc_t[i] = -1; seen[i] = 1'b0; free_at[i] = k + 1;
      end else if (acc_t[i] >= 0) begin
        if (k >= acc_t[i] + HOLD && (clr[i] || seen[i])) begin
          acc_t[i] = -1; seen[i] = 1'b0; free_at[i] = k + DEAD + 1;
        end else begin
          seen[i] = seen[i] | clr[i];
        end
      end else if (k >= free_at[i] && rise && !clr[i]) begin
        acc_t[i] = k;
        if (hits[i] < CMAX) hits[i]++;
      end
      eq[i] = (acc_t[i] >= 0);
      eb[i] = (acc_t[i] >= 0) || (k < free_at[i] - 1);
    end
    if (cnt_clr) for (int i = 0; i < W; i++) hits[i] = 0;
    exp_q.push_back(eq);
    exp_busy_q.push_back(eb);
    exp_cnt_q.push_back(ec);
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [CW-1:0] ec;
    @(posedge clk);
    if (rst) begin
      exp_q.push_back('0); exp_busy_q.push_back('0); exp_cnt_q.push_back('0);
    end else begin
      model_step();
    end
    @(negedge clk);
    check("q", 64'(q), 64'(exp_q.pop_front()));
    check("busy", 64'(busy), 64'(exp_busy_q.pop_front()));
    ec = exp_cnt_q.pop_front();
`ifdef TRIG_HIT_COUNT_EN
    check("cnt_out", 64'(cnt_out), 64'(ec));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic random_traffic(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(5) == 0) in_i[i] = ~in_i[i];
        clr[i] = ($urandom_range(9) == 0);
        en[i]  = ($urandom_range(39) != 0);
      end
      cnt_sel = SEL_W'($urandom_range(63));
      cnt_clr = ($urandom_range(49) == 0);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int hi_cnt, dead_cnt;
    in_i = '0; en = '1; clr = '0; cnt_sel = '0; cnt_clr = 1'b0; rst = 1'b1;

    // input held high through reset is never reported
    in_i[0] = 1'b1;
    do_reset();
    check("reset_q", 64'(q), 64'(0));
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t1_q0_held", 64'(q[0]), 64'(0));
    end
    in_i[0] = 1'b0;
    repeat (4) tick();

    // single pulse: latency, hold with early clear, dead time
    in_i[5] = 1'b1; tick();
    check("t2_q5_lat1", 64'(q[5]), 64'(0));
    in_i[5] = 1'b0; tick();
    check("t2_q5_lat2", 64'(q[5]), 64'(0));
    tick();
    check("t2_q5_rise", 64'(q[5]), 64'(1));
    hi_cnt = 1; dead_cnt = 0;
    clr[5] = 1'b1; tick(); clr[5] = 1'b0;
    hi_cnt += int'(q[5]);
    for (int c = 0; c < 16; c++) begin
      tick();
      hi_cnt   += int'(q[5]);
      dead_cnt += int'(busy[5] & ~q[5]);
    end
    check("t2_hold_len", 64'(hi_cnt), 64'(HOLD));
    check("t2_dead_len", 64'(dead_cnt), 64'(DEAD));

    // edge in DEAD and on the DEAD->IDLE cycle ignored; first IDLE cycle accepted
    for (int off = 0; off < 2; off++) begin
      for (int t = 0; t < 40; t++) begin
        in_i[5] = (t == 0) || (off == 1 && t == 7) || (t >= 12 + off && t <= 13 + off);
        clr[5]  = (t == 3) || (t == 17);
        tick();
        if (t == 14 + off) check($sformatf("t3_q5_off%0d", off), 64'(q[5]), 64'(off));
      end
    end
    in_i[5] = 1'b0; clr[5] = 1'b0;

    // clear dominates a same-cycle edge; masked channel ignores edges
    for (int t = 0; t < 6; t++) begin
      in_i[7] = (t == 0); in_i[9] = (t == 0);
      clr[7]  = (t == 2);
      en[9]   = (t > 4);
      tick();
      if (t == 2 || t == 5) begin
        check("t4_q7", 64'(q[7]), 64'(0));
        check("t4_q9", 64'(q[9]), 64'(0));
      end
    end
    clr[7] = 1'b0;

    // 17 accepted edges on ch3 saturate a 4-bit counter
    for (int r = 0; r < 17; r++) begin
      in_i[3] = 1'b1; tick();
      in_i[3] = 1'b0; tick();
      tick();
      check("t5_q3_set", 64'(q[3]), 64'(1));
      clr[3] = 1'b1; tick(); clr[3] = 1'b0;
      repeat (14) tick();
    end
    cnt_sel = SEL_W'(9); tick(); tick();
`ifdef TRIG_HIT_COUNT_EN
    check("t4_cnt9", 64'(cnt_out), 64'(0));
`endif
    cnt_sel = SEL_W'(3); tick();
`ifdef TRIG_HIT_COUNT_EN
    check("t5_cnt3_sat", 64'(cnt_out), 64'(CMAX));
`endif
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    tick();
`ifdef TRIG_HIT_COUNT_EN
    check("t5_cnt3_clr", 64'(cnt_out), 64'(0));
`endif

    // async reset while latched; edge inside the arm window is dropped
    in_i[2] = 1'b1; tick();
    in_i[2] = 1'b0; tick(); tick();
    check("t6_q2_set", 64'(q[2]), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_async_q", 64'(q), 64'(0));
    check("t6_async_busy", 64'(busy), 64'(0));
    model_reset();
    tick(); tick();
    rst = 1'b0;
    in_i[2] = 1'b1; tick();
    in_i[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t6_q2_arm", 64'(q[2]), 64'(0));
    end

    // random traffic, with an asynchronous reset in the middle
    random_traffic(300);
    #2 rst = 1'b1;
    #1;
    check("rand_async_q", 64'(q), 64'(0));
    model_reset();
    tick();
    rst = 1'b0;
    random_traffic(300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
